// File: rtl/riscy_pkg.sv
// riscy_pkg: shared phase names and defaults for the RISC-Y sequence controller
package riscy_pkg;
  typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, UPDATE} phase_e;
  localparam int DEFAULT_NUM_PHASES = 4;
endpackage

// File: rtl/dwell_counter.sv
// dwell_counter: counts run cycles inside a phase against a dwell latched on phase entry
module dwell_counter #(
  parameter int DWELL_W = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               load,
  input  logic               inc,
  input  logic [DWELL_W-1:0] dwell,
  output logic               tc
);
  logic [DWELL_W-1:0] cnt, lat;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      cnt <= '0;
      lat <= '0;
    end else if (load) begin
      cnt <= '0;
      lat <= dwell;
    end else if (inc) cnt <= cnt + 1'b1;
  assign tc = cnt == lat;
endmodule

// File: rtl/phase_sequencer.sv
// phase_sequencer: N-phase cycle generator with dwell, hold, directed jump and boundary strobes
module phase_sequencer import riscy_pkg::*; #(
  parameter int NUM_PHASES = DEFAULT_NUM_PHASES,
  parameter int PHASE_W    = $clog2(NUM_PHASES),
  parameter int DWELL_W    = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN_N,
  input  logic                  HOLD,
  input  logic [DWELL_W-1:0]    DWELL,
  input  logic                  JUMP_VLD,
  input  logic [PHASE_W-1:0]    JUMP_PHASE,
  output logic [PHASE_W-1:0]    PHASE,
  output logic [NUM_PHASES-1:0] PHASE_OH,
  output logic                  PHASE_START,
  output logic                  WRAP,
  output logic                  ARMED,
  output logic                  JUMP_ERR
);
  localparam logic [PHASE_W-1:0] LAST = PHASE_W'(NUM_PHASES - 1);
  logic tc, jump_ok, run, adv, inc, load;
  logic [PHASE_W-1:0] phase_d;
  dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
    .CLK(CLK), .RST(RST), .load(load), .inc(inc), .dwell(DWELL), .tc(tc)
  );
  // a pending jump outranks hold and run, so run excludes JUMP_VLD outright
  always_comb begin
    jump_ok = ARMED & JUMP_VLD & ({1'b0, JUMP_PHASE} < (PHASE_W + 1)'(NUM_PHASES));
    run     = ARMED & ~EN_N & ~HOLD & ~JUMP_VLD;
    adv     = run & tc;
    inc     = run & ~tc;
    load    = ~ARMED | jump_ok | adv;
    phase_d = jump_ok ? JUMP_PHASE : adv ? (PHASE == LAST ? '0 : PHASE + 1'b1) : PHASE;
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      PHASE       <= '0;
      PHASE_OH    <= NUM_PHASES'(1);
      PHASE_START <= 1'b0;
      WRAP        <= 1'b0;
      ARMED       <= 1'b0;
      JUMP_ERR    <= 1'b0;
    end else begin
      PHASE       <= phase_d;
      PHASE_OH    <= NUM_PHASES'(1) << phase_d;
      PHASE_START <= load;
      WRAP        <= adv & (PHASE == LAST);
      ARMED       <= 1'b1;
      JUMP_ERR    <= ARMED & JUMP_VLD & ~jump_ok;
    end
endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: random stimulus on 4-, 5- and 6-phase instances checked against a remaining-cycles model
module tb_phase_sequencer;
  logic CLK = 1'b0, RST = 1'b0, EN_N = 1'b0, HOLD = 1'b0, JUMP_VLD = 1'b0;
  logic [3:0] DWELL = '0;
  logic [2:0] jp = '0;
  logic [2:0] ph [3];
  logic [5:0] oh [3];
  logic st [3], wr [3], ar [3], er [3];
  int vectors = 0, miscompares = 0;
  int mph [3], mleft [3];
  bit marm [3], mst [3], mwr [3], mer [3];
  always #5 CLK = ~CLK;

  function automatic int np(int i);
    return i == 0 ? 4 : i == 1 ? 5 : 6;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int N = g == 0 ? 4 : g == 1 ? 5 : 6;
    localparam int PW = $clog2(N);
    logic [PW-1:0] p;
    logic [N-1:0] o;
    phase_sequencer #(.NUM_PHASES(N)) dut (
      .CLK(CLK), .RST(RST), .EN_N(EN_N), .HOLD(HOLD), .DWELL(DWELL),
      .JUMP_VLD(JUMP_VLD), .JUMP_PHASE(jp[PW-1:0]), .PHASE(p), .PHASE_OH(o),
      .PHASE_START(st[g]), .WRAP(wr[g]), .ARMED(ar[g]), .JUMP_ERR(er[g])
    );
    assign ph[g] = 3'(p);
    assign oh[g] = 6'(o);
  end

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mph[i] = 0; mleft[i] = 0;
      marm[i] = 0; mst[i] = 0; mwr[i] = 0; mer[i] = 0;
    end
  endtask

  // phase occupancy modelled as cycles still to spend in the phase
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int n = np(i);
      int tgt = (i == 0) ? int'(jp) % 4 : int'(jp);
      mst[i] = 0; mwr[i] = 0; mer[i] = 0;
      if (!marm[i]) begin
        marm[i] = 1; mst[i] = 1; mleft[i] = int'(DWELL);
      end else if (JUMP_VLD) begin
        if (tgt < n) begin
          mph[i] = tgt; mleft[i] = int'(DWELL); mst[i] = 1;
        end else mer[i] = 1;
      end else if (!EN_N && !HOLD) begin
        if (mleft[i] > 0) mleft[i]--;
        else begin
          mwr[i] = mph[i] == n - 1;
          mph[i] = (mph[i] + 1) % n;
          mleft[i] = int'(DWELL);
          mst[i] = 1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s n%0d PHASE", tag, np(i)), int'(ph[i]), mph[i]);
      chk($sformatf("%s n%0d PHASE_OH", tag, np(i)), int'(oh[i]), 1 << mph[i]);
      chk($sformatf("%s n%0d PHASE_START", tag, np(i)), int'(st[i]), int'(mst[i]));
      chk($sformatf("%s n%0d WRAP", tag, np(i)), int'(wr[i]), int'(mwr[i]));
      chk($sformatf("%s n%0d ARMED", tag, np(i)), int'(ar[i]), int'(marm[i]));
      chk($sformatf("%s n%0d JUMP_ERR", tag, np(i)), int'(er[i]), int'(mer[i]));
    end
  endtask

  initial begin
    model_reset();
    repeat (3) begin
      @(posedge CLK); #1;
      check_all("reset");
    end
    for (int k = 0; k < 2500; k++) begin
      @(negedge CLK);
      RST = 1'b1;
      EN_N = $urandom_range(0, 7) == 0;
      HOLD = $urandom_range(0, 7) == 0;
      JUMP_VLD = $urandom_range(0, 11) == 0;
      jp = 3'($urandom_range(0, 7));
      if (k < 300) DWELL = '0;
      else if ($urandom_range(0, 49) == 0) DWELL = 4'd15;
      else if ($urandom_range(0, 9) == 0) DWELL = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) begin
        #2;
        RST = 1'b0;
        #1;
        model_reset();
        check_all("async");
      end else model_step();
      @(posedge CLK); #1;
      check_all("edge");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Parametrised N-phase cycle generator for the RISC-Y sequence controller; successor to the fixed 4-phase FETCH/DECODE/EXECUTE/UPDATE phaser.
- Adds:
  - configurable phase count
  - per-phase dwell (multi-cycle phases)
  - hold/stall
  - directed jump
  - one-hot output
  - phase-boundary strobes
- Sits between the clock/reset tree and the sequence controller. All outputs are registered.

Parameters:
NUM_PHASES, 4, number of phases in one cycle; legal range 2..16
PHASE_W, $clog2(NUM_PHASES), width of encoded phase
DWELL_W, 4, width of dwell-count input

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-low
EN_N  input  1  advance enable, active-low (0 = sequencer runs)
HOLD  input  1  freeze current phase and dwell counter (stall)
DWELL  input  DWELL_W  extra cycles per phase; phase lasts DWELL+1 run cycles; sampled on phase entry
JUMP_VLD  input  1  load JUMP_PHASE as next phase
JUMP_PHASE  input  PHASE_W  target phase for jump
PHASE  output  PHASE_W  encoded current phase
PHASE_OH  output  NUM_PHASES  one-hot current phase
PHASE_START  output  1  high for the first cycle of each phase occupancy
WRAP  output  1  one-cycle pulse on the transition from phase NUM_PHASES-1 to 0
ARMED  output  1  sequencer armed (first clock after reset release seen)
JUMP_ERR  output  1  one-cycle pulse when JUMP_PHASE >= NUM_PHASES

Behaviour:
- Reset (RST=0, async) sets the following; all are held while RST=0:
  - PHASE=0, PHASE_OH=1, dwell counter=0, latched dwell=0
  - PHASE_START=0, WRAP=0, JUMP_ERR=0, ARMED=0
- Arm: the first rising CLK with RST=1 sets ARMED=1 and PHASE_START=1 and latches DWELL. No advance on that edge. Until ARMED=1, no advance or jump occurs.
- "Run cycle": ARMED=1 and EN_N=0 and HOLD=0.
- Per-edge priority, highest first:
  1. Reset.
  2. Jump: JUMP_VLD=1 with ARMED=1, regardless of EN_N/HOLD.
     - In range: next PHASE=JUMP_PHASE, counter=0, DWELL re-latched, PHASE_START=1, WRAP=0.
     - Out of range (>= NUM_PHASES): state unchanged, JUMP_ERR=1 for one cycle.
  3. Hold: EN_N=1 or HOLD=1 freezes PHASE and the counter. PHASE_START=0, WRAP=0.
  4. Run cycle, counter < latched dwell: counter+1, phase unchanged.
  5. Run cycle, counter == latched dwell: advance and reset counter.
     - PHASE = (PHASE == NUM_PHASES-1) ? 0 : PHASE+1
     - counter=0, DWELL re-latched, PHASE_START=1
     - WRAP=1 iff the old PHASE was NUM_PHASES-1
- DWELL=0 gives one phase per run cycle: the 4-phase, single-cycle behaviour of the predecessor when NUM_PHASES=4.
- PHASE_OH always equals 1<<PHASE; both are updated on the same edge. Encoded values >= NUM_PHASES are never produced.
- Changing DWELL mid-phase has no effect until the next phase entry.
- Reset asserted mid-phase or mid-hold: immediate return to reset values. Re-arm is required.
- Latency: a JUMP_VLD or advance condition at edge k is visible on outputs after edge k (one register stage).

Decomposition:
- Shared package riscy_pkg:
  - typedef enum phase_e {FETCH, DECODE, EXECUTE, UPDATE} for the default 4-phase use
  - localparam DEFAULT_NUM_PHASES=4
- One natural sub-module: dwell_counter (DWELL_W-bit counter with load/clear/hold, terminal-count output). The phase register and strobes stay in the top.

Test Plan:
- Reset and arm, NUM_PHASES=4, DWELL=0, EN_N=0: RST low 3 cycles, then high → ARMED=1 after the 1st edge. PHASE then goes 0,1,2,3,0 on successive edges, with WRAP=1 only on the 3→0 edge and PHASE_OH=0001,0010,0100,1000,0001.
- Dwell, DWELL=2: each phase lasts 3 cycles, so PHASE=0,0,0,1,1,1,2… PHASE_START is high on the 1st cycle of each group only. Changing DWELL to 0 mid-phase 1 takes effect from phase 2.
- Hold/enable:
  - HOLD=1 for 5 cycles during phase 2, counter=1 → PHASE stays 2, counter stays 1, and the phase completes its remaining cycles after release.
  - EN_N=1 gives the same result.
- Jump, NUM_PHASES=6:
  - JUMP_VLD=1, JUMP_PHASE=4 while HOLD=1 → PHASE=4, PHASE_OH=010000, PHASE_START=1.
  - JUMP_PHASE=7 → state unchanged, JUMP_ERR pulse for 1 cycle.
- Wrap at non-power-of-two, NUM_PHASES=5: free-run 12 cycles → sequence 0..4,0..4,0,1. Never 5..7. WRAP pulses twice.
- Async reset mid-operation: RST low between edges while PHASE=3, DWELL=5 → outputs return to reset values immediately, without waiting for CLK. No advance before re-arm.
